dig_scan_driver: RTL and testbench
==================================

# dig_scan_driver

Bus-slave peripheral that drives the board's eight-digit, seven-segment display. It sits downstream of the system bus bridge on the 7-seg digital LED port (rst/clk/addr/we/wdata) and drives the top-level `dig_en`, `DN_A`..`DN_G` and `DN_DP` pins. It holds a 32-bit display word and a control word written by the CPU. It time-multiplexes the eight digits with a programmable scan prescaler and hex-decodes one nibble per digit.

## Interface
- `SCAN_DIV`, 20000: clock cycles per digit slot; must be ≥2.
- `clk` input 1: bridge-supplied clock (cpu_clk domain).
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `addr` input 32: bus address; only `addr[3:2]` is decoded.
- `we` input 1: write strobe, one cycle per store.
- `wdata` input 32: store data.
- `dig_en` output 8: digit selects, active-low; bit 0 is the rightmost digit.
- `DN_A`..`DN_G` output 1 each: segments, active-low.
- `DN_DP` output 1: decimal point, active-low.

## Operation
- Register map (write-only, word access):
  - `addr[3:2]=0`: DATA[31:0]. Digit i shows hex of DATA[4i+3:4i].
  - `addr[3:2]=1`: CTRL. Bit 0 is EN. Bits [15:8] are DIGIT_MASK (1 = digit lit). Bits [23:16] are DP_MASK (1 = DP lit). All other bits are ignored.
  - `addr[3:2]=2,3`: the write is ignored.
- Reset values: DATA=0, CTRL=0x0000_FF01, scan counter `cnt`=0, digit index `idx`=0, `dig_en`=8'hFF, all segment and DP outputs = 1 (dark).
- Prescaler:
  - `cnt` counts 0..SCAN_DIV-1 and wraps.
  - On the cycle where `cnt==SCAN_DIV-1`, `idx` advances, wrapping 7 to 0.
  - `cnt` and `idx` run whether EN is 1 or 0.
- Output function f(idx, DATA, CTRL):
  - If EN=0 or DIGIT_MASK[idx]=0: `dig_en`=8'hFF and all segments are dark.
  - Otherwise `dig_en` = ~(1<<idx), segments = hex pattern of the selected nibble, and `DN_DP` = ~DP_MASK[idx].
- Hex patterns use standard a–g segments. 0–9 are conventional. A,b,C,d,E,F use their conventional forms: b and d are lowercase, C is uppercase.
- The output registers load f(...) on every clock edge.
- Simultaneous events:
  - A write and a digit advance in the same cycle are independent. The new value shows on the first output load after the write.
  - Two writes on consecutive cycles: the last one wins.
- Reset mid-scan: all state returns to its reset value immediately and the pins go dark at once (asynchronous).

## Timing
- Write with `we=1` at edge N: DATA or CTRL is updated at N, and the pins reflect it at edge N+1.
- Digit advance: `idx` changes at the edge where `cnt==SCAN_DIV-1`. The pins show the new digit one edge later.
- A full refresh period is 8×SCAN_DIV cycles.
- After `rst_n` deasserts: the first edge loads pins for digit 0 (visible because of the reset CTRL).
  - Digit 0 stays active until `idx` first advances, after SCAN_DIV edges.
  - Once the advance reaches the pins, each digit occupies exactly SCAN_DIV cycles.
- There are no glitches: every pin is driven directly from a flop.

## Structure
- Add to `defines.vh`:
  - the base address of the digit peripheral
  - `DIG_DATA_OFS`=0x0 and `DIG_CTRL_OFS`=0x4
  - `DIG_CTRL_RST`=32'h0000_FF01
  - the 16 segment patterns as named constants
- One sub-module, `seg7_hex_decode`: combinational, 4-bit nibble in, 7-bit active-low segments out.
- The top level contains the register file, the prescaler/index counter and the output flops.

## Test plan
Benches use SCAN_DIV=4.
- Reset then release, DATA untouched: only `dig_en`=8'hFE is active, with segments showing "0" (gfedcba=7'b1000000), for 4 cycles. It then steps to 8'hFD. After 32 cycles it is back at 8'hFE.
- Write DATA=0x89AB_CDEF: across one 32-cycle period, digits 0..7 show F,E,d,C,b,A,9,8 with `DN_DP`=1. Pins change one edge after the write.
- Write CTRL=0x0081_0501: only digits 0 and 2 are ever lit. The other slots are fully dark but keep their 4-cycle duration. DP is lit on digit 0 only.
- Write CTRL=0x0000_FF00 (EN=0): `dig_en` stays 8'hFF. Re-enabling resumes at the current `idx`, not at digit 0.
- Write to `addr[3:2]=2` with wdata=0xFFFF_FFFF: DATA and CTRL are unchanged.
- Assert `rst_n`=0 mid-slot on digit 5: the pins go dark in the same cycle with no clock edge. Release: the scan restarts at digit 0 with DATA=0.

Source files
------------

// File: rtl/dig_scan_driver_pkg.sv
// Shared constants for the eight-digit seven-segment scan driver: register
// offsets, reset control word and the active-low hex segment patterns.
package dig_scan_driver_pkg;

    localparam logic [31:0] DIG_BASE_ADDR = 32'h1000_F000;
    localparam logic [31:0] DIG_DATA_OFS  = 32'h0000_0000;
    localparam logic [31:0] DIG_CTRL_OFS  = 32'h0000_0004;
    localparam logic [31:0] DIG_CTRL_RST  = 32'h0000_FF01;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0 = 7'b100_0000;
    localparam logic [6:0] SEG_1 = 7'b111_1001;
    localparam logic [6:0] SEG_2 = 7'b010_0100;
    localparam logic [6:0] SEG_3 = 7'b011_0000;
    localparam logic [6:0] SEG_4 = 7'b001_1001;
    localparam logic [6:0] SEG_5 = 7'b001_0010;
    localparam logic [6:0] SEG_6 = 7'b000_0010;
    localparam logic [6:0] SEG_7 = 7'b111_1000;
    localparam logic [6:0] SEG_8 = 7'b000_0000;
    localparam logic [6:0] SEG_9 = 7'b001_0000;
    localparam logic [6:0] SEG_A = 7'b000_1000;
    localparam logic [6:0] SEG_B = 7'b000_0011;
    localparam logic [6:0] SEG_C = 7'b100_0110;
    localparam logic [6:0] SEG_D = 7'b010_0001;
    localparam logic [6:0] SEG_E = 7'b000_0110;
    localparam logic [6:0] SEG_F = 7'b000_1110;
    localparam logic [6:0] SEG_DARK = 7'b111_1111;

    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_CTRL  = 2'd1,
        REG_RSVD2 = 2'd2,
        REG_RSVD3 = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic [7:0] dp_mask;
        logic [7:0] digit_mask;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/dig_scan_driver_seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_hex_decode
    import dig_scan_driver_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_DARK;
        case (nibble_i)
            4'h0: seg_n_o = SEG_0;
            4'h1: seg_n_o = SEG_1;
            4'h2: seg_n_o = SEG_2;
            4'h3: seg_n_o = SEG_3;
            4'h4: seg_n_o = SEG_4;
            4'h5: seg_n_o = SEG_5;
            4'h6: seg_n_o = SEG_6;
            4'h7: seg_n_o = SEG_7;
            4'h8: seg_n_o = SEG_8;
            4'h9: seg_n_o = SEG_9;
            4'hA: seg_n_o = SEG_A;
            4'hB: seg_n_o = SEG_B;
            4'hC: seg_n_o = SEG_C;
            4'hD: seg_n_o = SEG_D;
            4'hE: seg_n_o = SEG_E;
            4'hF: seg_n_o = SEG_F;
            default: seg_n_o = SEG_DARK;
        endcase
    end

endmodule

// File: rtl/dig_scan_driver.sv
// Bus-slave seven-segment scan driver: DATA/CTRL registers, digit prescaler
// and registered active-low pin outputs.
module dig_scan_driver
    import dig_scan_driver_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [7:0]  dig_en,
    output logic        DN_A,
    output logic        DN_B,
    output logic        DN_C,
    output logic        DN_D,
    output logic        DN_E,
    output logic        DN_F,
    output logic        DN_G,
    output logic        DN_DP
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam ctrl_t CTRL_RST = '{
        dp_mask:    DIG_CTRL_RST[23:16],
        digit_mask: DIG_CTRL_RST[15:8],
        en:         DIG_CTRL_RST[0]
    };

    logic [31:0]      data_q, data_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       dig_en_q, dig_en_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0]       nibble;
    logic [6:0]       seg_hex;
    logic             lit;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

    seg7_hex_decode u_decode (
        .nibble_i (nibble),
        .seg_n_o  (seg_hex)
    );

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (we) begin
            case (reg_sel_e'(addr[3:2]))
                REG_DATA: data_d = wdata;
                REG_CTRL: ctrl_d = '{dp_mask: wdata[23:16], digit_mask: wdata[15:8], en: wdata[0]};
                default:  ;
            endcase
        end
    end

    // The prescaler free-runs regardless of EN so re-enabling resumes mid-scan.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Pins are computed from the registered state, so they trail writes and
    // digit advances by exactly one edge.
    always_comb begin
        nibble   = data_q[{idx_q, 2'b00} +: 4];
        lit      = ctrl_q.en & ctrl_q.digit_mask[idx_q];
        dig_en_d = 8'hFF;
        seg_d    = SEG_DARK;
        dp_d     = 1'b1;
        if (lit) begin
            dig_en_d = ~(8'd1 << idx_q);
            seg_d    = seg_hex;
            dp_d     = ~ctrl_q.dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            ctrl_q   <= CTRL_RST;
            cnt_q    <= '0;
            idx_q    <= '0;
            dig_en_q <= 8'hFF;
            seg_q    <= SEG_DARK;
            dp_q     <= 1'b1;
        end else begin
            data_q   <= data_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dig_en_q <= dig_en_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign dig_en = dig_en_q;
    assign DN_A   = seg_q[0];
    assign DN_B   = seg_q[1];
    assign DN_C   = seg_q[2];
    assign DN_D   = seg_q[3];
    assign DN_E   = seg_q[4];
    assign DN_F   = seg_q[5];
    assign DN_G   = seg_q[6];
    assign DN_DP  = dp_q;

endmodule

// File: tb/tb_dig_scan_driver.sv
// Bench for dig_scan_driver: an elapsed-time display model checked every
// cycle, plus hand-computed pin values at chosen points of the scan.
module tb_dig_scan_driver;
    import dig_scan_driver_pkg::*;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [7:0]  dig_en;
    logic        DN_A, DN_B, DN_C, DN_D, DN_E, DN_F, DN_G, DN_DP;
    logic [6:0]  seg_w;

    assign seg_w = {DN_G, DN_F, DN_E, DN_D, DN_C, DN_B, DN_A};

    dig_scan_driver #(.SCAN_DIV(SD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .dig_en (dig_en),
        .DN_A   (DN_A),
        .DN_B   (DN_B),
        .DN_C   (DN_C),
        .DN_D   (DN_D),
        .DN_E   (DN_E),
        .DN_F   (DN_F),
        .DN_G   (DN_G),
        .DN_DP  (DN_DP)
    );

    always #5 clk = ~clk;

    // {g..a}, active-low, for hex digits 0..F
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Expected pins {dig_en, seg, dp} while digit d is the one being scanned.
    function automatic logic [15:0] pins_for(input int d, input logic [31:0] data,
                                             input logic [31:0] ctrl);
        logic [7:0] sel;
        if (ctrl[0] == 1'b0 || ctrl[8 + d] == 1'b0)
            return 16'hFFFF;
        sel = 8'd1 << d;
        return {~sel, hex_tab[data[4*d +: 4]], ~ctrl[16 + d]};
    endfunction

    // Model: the n-th edge after reset release shows digit (n/SD) mod 8 using
    // the register contents from before that edge.
    logic [31:0] m_data;
    logic [31:0] m_ctrl;
    int          k_edges;
    logic [15:0] exp_v = 16'hFFFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= 32'h0;
            m_ctrl  <= 32'h0000_FF01;
            k_edges <= 0;
            exp_v   <= 16'hFFFF;
        end else begin
            exp_v   <= pins_for((k_edges / SD) % 8, m_data, m_ctrl);
            k_edges <= k_edges + 1;
            if (we) begin
                if (addr[3:2] == 2'd0) m_data <= wdata;
                else if (addr[3:2] == 2'd1) m_ctrl <= wdata;
            end
        end
    end

    int          vectors = 0;
    int          errors  = 0;
    logic        check_on = 1'b0;
    logic        lit_valid = 1'b0;
    logic [15:0] lit_v = 16'h0;
    string       lit_name = "";

    always @(negedge clk or negedge rst_n) begin
        #1;
        if (check_on) begin
            vectors++;
            if ({dig_en, seg_w, DN_DP} !== exp_v) begin
                errors++;
                $display("FAIL model_cmp t=%0t dig_en=%h seg=%h dp=%b required=%h",
                         $time, dig_en, seg_w, DN_DP, exp_v);
            end
            if (lit_valid) begin
                vectors += 2;
                $display("vec %s: dut=%h model=%h want=%h", lit_name,
                         {dig_en, seg_w, DN_DP}, exp_v, lit_v);
                if ({dig_en, seg_w, DN_DP} !== lit_v) begin
                    errors++;
                    $display("FAIL %s dut=%h required=%h", lit_name,
                             {dig_en, seg_w, DN_DP}, lit_v);
                end
                if (exp_v !== lit_v) begin
                    errors++;
                    $display("FAIL %s_model model=%h required=%h", lit_name, exp_v, lit_v);
                end
            end
        end
    end

    task automatic expect_lit(input string nm, input logic [7:0] de,
                              input logic [6:0] sg, input logic dp);
        lit_name  = nm;
        lit_v     = {de, sg, dp};
        lit_valid = 1'b1;
        #2;
        lit_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [31:0] d);
        addr  = DIG_BASE_ADDR + ofs;
        wdata = d;
        we    = 1'b1;
        $display("write addr=%h data=%h", addr, d);
        @(negedge clk);
        we    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        #1 rst_n = 1'b0;
        #1 check_on = 1'b1;
        @(negedge clk);
        expect_lit("reset_dark", 8'hFF, 7'h7F, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Edge counts below are edges since release.
        @(negedge clk);            expect_lit("e1_digit0", 8'hFE, 7'h40, 1'b1);
        repeat (3) @(negedge clk); expect_lit("e4_digit0", 8'hFE, 7'h40, 1'b1);
        @(negedge clk);            expect_lit("e5_digit1", 8'hFD, 7'h40, 1'b1);
        repeat (28) @(negedge clk); expect_lit("e33_wrap", 8'hFE, 7'h40, 1'b1);
        @(negedge clk);

        wr(DIG_DATA_OFS, 32'h89AB_CDEF);           // written at edge 35
        expect_lit("data_not_yet", 8'hFE, 7'h40, 1'b1);
        @(negedge clk);            expect_lit("data_F", 8'hFE, 7'h0E, 1'b1);
        @(negedge clk);            expect_lit("data_E", 8'hFD, 7'h06, 1'b1);
        repeat (4) @(negedge clk); expect_lit("data_d", 8'hFB, 7'h21, 1'b1);
        repeat (32) @(negedge clk);

        wr(DIG_CTRL_OFS, 32'h0081_0501);           // edge 74
        repeat (23) @(negedge clk); expect_lit("mask_d0_dp", 8'hFE, 7'h0E, 1'b0);
        repeat (4) @(negedge clk);  expect_lit("mask_d1_dark", 8'hFF, 7'h7F, 1'b1);
        repeat (4) @(negedge clk);  expect_lit("mask_d2", 8'hFB, 7'h21, 1'b1);

        wr(DIG_CTRL_OFS, 32'h0000_FF00);           // edge 106
        repeat (10) @(negedge clk); expect_lit("en_off", 8'hFF, 7'h7F, 1'b1);
        wr(DIG_CTRL_OFS, 32'h0000_FF01);           // edge 117
        @(negedge clk);             expect_lit("en_resume_d5", 8'hDF, 7'h08, 1'b1);

        wr(32'h0000_0008, 32'hFFFF_FFFF);          // edge 119, ignored
        repeat (16) @(negedge clk); expect_lit("rsvd_ignored", 8'hFD, 7'h06, 1'b1);
        repeat (15) @(negedge clk); expect_lit("pre_rst_d5", 8'hDF, 7'h08, 1'b1);

        @(posedge clk);
        #2;
        lit_name  = "async_rst";
        lit_v     = 16'hFFFF;
        lit_valid = 1'b1;
        rst_n     = 1'b0;
        #2;
        lit_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);            expect_lit("restart_d0", 8'hFE, 7'h40, 1'b1);

        wr(DIG_DATA_OFS, 32'h7654_3210);           // edge 2
        repeat (3) @(negedge clk); expect_lit("low_hex_1", 8'hFD, 7'h79, 1'b1);
        repeat (36) @(negedge clk);

        check_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
